// File: rtl/alu_result_serializer.sv
// alu_result_serializer: buffers ALU results in a FIFO and streams them out as bytes, LSB first, over valid/ready.
// Ports: CLK/RST (sync active-high), ALU_OUT+OUT_VALID capture strobe, TX_DATA/TX_VALID/TX_READY byte handshake,
// FIFO_FULL (count==DEPTH), DROP_PULSE (result discarded last cycle), BUSY (sending or FIFO non-empty).
// Optional: define ALU_RES_SEQ_HDR_EN to prefix every word with a sequence-number header byte.
module alu_result_serializer #(
  parameter int IN_WIDTH   = 16,
  parameter int BYTE_WIDTH = 8,
  parameter int DEPTH      = 4
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [IN_WIDTH-1:0]   ALU_OUT,
  input  logic                  OUT_VALID,
  output logic [BYTE_WIDTH-1:0] TX_DATA,
  output logic                  TX_VALID,
  input  logic                  TX_READY,
  output logic                  FIFO_FULL,
  output logic                  DROP_PULSE,
  output logic                  BUSY
);
  localparam int BYTES = IN_WIDTH / BYTE_WIDTH;
  localparam int AW    = $clog2(DEPTH);
`ifdef ALU_RES_SEQ_HDR_EN
  localparam int LAST  = BYTES;
`else
  localparam int LAST  = BYTES - 1;
`endif
  localparam int CW    = $clog2(LAST + 2);
  typedef enum logic {IDLE, SEND} state_e;
  logic [IN_WIDTH-1:0]   mem_q [DEPTH];
  logic [AW-1:0]         wptr_q, rptr_q;
  logic [AW:0]           count_q, count_d;
  logic [IN_WIDTH-1:0]   sh_q, sh_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  state_e                state_q, state_d;
  logic                  drop_q;
  logic                  accept, last, pop, push, is_hdr;
  assign accept = state_q == SEND && TX_READY;
  assign last   = cnt_q == CW'(LAST);
  assign pop    = count_q != '0 && (state_q == IDLE || (accept && last));
  assign push   = OUT_VALID && (count_q != (AW+1)'(DEPTH) || pop);
`ifdef ALU_RES_SEQ_HDR_EN
  logic [BYTE_WIDTH-1:0] seq_q;
  // transfer 0 of every word is the header; data bytes follow at cnt 1..BYTES
  assign is_hdr = cnt_q == '0;
  always_ff @(posedge CLK)
    if (RST) seq_q <= '0;
    else if (accept && is_hdr) seq_q <= seq_q + 1'b1;
  assign TX_DATA = state_q != SEND ? '0 : is_hdr ? seq_q : sh_q[BYTE_WIDTH-1:0];
`else
  assign is_hdr  = 1'b0;
  assign TX_DATA = state_q == SEND ? sh_q[BYTE_WIDTH-1:0] : '0;
`endif
  assign TX_VALID   = state_q == SEND;
  assign FIFO_FULL  = count_q == (AW+1)'(DEPTH);
  assign DROP_PULSE = drop_q;
  assign BUSY       = state_q == SEND || count_q != '0;
  assign count_d    = count_q + (AW+1)'(push) - (AW+1)'(pop);
  always_comb begin
    state_d = state_q;
    sh_d    = sh_q;
    cnt_d   = cnt_q;
    if (pop) begin
      state_d = SEND;
      sh_d    = mem_q[rptr_q];
      cnt_d   = '0;
    end else if (accept) begin
      state_d = last ? IDLE : SEND;
      cnt_d   = last ? cnt_q : cnt_q + CW'(1);
      sh_d    = last || is_hdr ? sh_q : sh_q >> BYTE_WIDTH;
    end
  end
  always_ff @(posedge CLK)
    if (push) mem_q[wptr_q] <= ALU_OUT;
  always_ff @(posedge CLK)
    if (RST) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      sh_q    <= '0;
      cnt_q   <= '0;
      state_q <= IDLE;
      drop_q  <= 1'b0;
    end else begin
      wptr_q  <= wptr_q + AW'(push);
      rptr_q  <= rptr_q + AW'(pop);
      count_q <= count_d;
      sh_q    <= sh_d;
      cnt_q   <= cnt_d;
      state_q <= state_d;
      drop_q  <= OUT_VALID && !push;
    end
endmodule

// File: tb/tb_alu_result_serializer.sv
// tb_alu_result_serializer: table-driven and scoreboard checks of the byte serializer.
module tb_alu_result_serializer;
`ifdef ALU_RES_SEQ_HDR_EN
  localparam int H = 1;
`else
  localparam int H = 0;
`endif
  logic        CLK = 0, RST = 1, OUT_VALID = 0, TX_READY = 0;
  logic [15:0] ALU_OUT = '0;
  logic [7:0]  TX_DATA;
  logic        TX_VALID, FIFO_FULL, DROP_PULSE, BUSY;
  int          n_cmp = 0, n_bad = 0;
  logic [7:0]  exp_q [$];
  logic [7:0]  seq_tb = '0;
  alu_result_serializer dut (
    .CLK(CLK), .RST(RST), .ALU_OUT(ALU_OUT), .OUT_VALID(OUT_VALID),
    .TX_DATA(TX_DATA), .TX_VALID(TX_VALID), .TX_READY(TX_READY),
    .FIFO_FULL(FIFO_FULL), .DROP_PULSE(DROP_PULSE), .BUSY(BUSY)
  );
  always #5 CLK = ~CLK;
  typedef struct {
    logic [15:0] din;
    int          stall;
    logic [7:0]  b0;
    logic [7:0]  b1;
  } vec_t;
  vec_t vecs [4];
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  always @(negedge CLK)
    if (!RST && TX_VALID && TX_READY) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL spurious_byte: got %0h expected none", TX_DATA);
      end else chk("byte", TX_DATA, exp_q.pop_front());
    end
  task automatic push_hdr();
    if (H == 1) begin
      exp_q.push_back(seq_tb);
      seq_tb++;
    end
  endtask
  task automatic push_word(input logic [15:0] w);
    push_hdr();
    exp_q.push_back(w[7:0]);
    exp_q.push_back(w[15:8]);
  endtask
  task automatic pulse(input logic [15:0] w);
    @(posedge CLK); #1 ALU_OUT = w; OUT_VALID = 1;
    @(posedge CLK); #1 OUT_VALID = 0;
  endtask
  task automatic drain(input int max);
    for (int i = 0; i < max; i++) begin
      if (exp_q.size() == 0) break;
      @(posedge CLK);
    end
    chk("drain_left", exp_q.size(), 0);
  endtask
  initial begin
    int nv, run;
    vecs[0] = '{16'hBEEF, 5, 8'hEF, 8'hBE};
    vecs[1] = '{16'h0000, 1, 8'h00, 8'h00};
    vecs[2] = '{16'hFFFF, 2, 8'hFF, 8'hFF};
    vecs[3] = '{16'hA55A, 3, 8'h5A, 8'hA5};
    repeat (2) @(posedge CLK);
    #1 RST = 0;
    @(negedge CLK);
    chk("rst_valid", TX_VALID, 0);
    chk("rst_data", TX_DATA, 0);
    chk("rst_full", FIFO_FULL, 0);
    chk("rst_drop", DROP_PULSE, 0);
    chk("rst_busy", BUSY, 0);
    // latency and throughput of a single word
    TX_READY = 1;
    push_word(16'h1234);
    pulse(16'h1234);
    @(negedge CLK);
    chk("lat_idle", TX_VALID, 0);
    nv = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge CLK);
      if (i == 0) chk("lat_first", TX_VALID, 1);
      if (TX_VALID) nv++;
    end
    chk("valid_cycles", nv, 2 + H);
    chk("busy_done", BUSY, 0);
    chk("drain1", exp_q.size(), 0);
    // stalled single words from the table
    for (int v = 0; v < 4; v++) begin
      TX_READY = 0;
      push_hdr();
      exp_q.push_back(vecs[v].b0);
      exp_q.push_back(vecs[v].b1);
      pulse(vecs[v].din);
      @(posedge CLK);
      for (int s = 0; s < vecs[v].stall; s++) begin
        @(negedge CLK);
        chk("stall_valid", TX_VALID, 1);
        chk("stall_data", TX_DATA, exp_q[0]);
        @(posedge CLK);
      end
      #1 TX_READY = 1;
      drain(20);
      @(negedge CLK);
      chk("vec_busy", BUSY, 0);
    end
    // overflow: one word in the shifter, four in the FIFO, sixth dropped
    TX_READY = 0;
    for (int i = 1; i <= 6; i++) begin
      @(posedge CLK); #1 ALU_OUT = 16'(i); OUT_VALID = 1;
      if (i <= 5) push_word(16'(i));
      if (i == 5) begin
        chk("not_full_yet", FIFO_FULL, 0);
        chk("no_drop_yet", DROP_PULSE, 0);
      end
    end
    @(posedge CLK); #1 OUT_VALID = 0;
    @(negedge CLK);
    chk("full", FIFO_FULL, 1);
    chk("drop", DROP_PULSE, 1);
    @(negedge CLK);
    chk("drop_one_cycle", DROP_PULSE, 0);
    chk("still_full", FIFO_FULL, 1);
    TX_READY = 1;
    drain(60);
    @(negedge CLK);
    chk("ovf_busy", BUSY, 0);
    // back-to-back words stream without a bubble
    push_word(16'hAAAA);
    push_word(16'h5555);
    @(posedge CLK); #1 ALU_OUT = 16'hAAAA; OUT_VALID = 1;
    @(posedge CLK); #1 ALU_OUT = 16'h5555;
    @(posedge CLK); #1 OUT_VALID = 0;
    run = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge CLK);
      if (TX_VALID) run++;
      else if (run > 0) break;
    end
    chk("b2b_run", run, 2 * (2 + H));
    drain(10);
    // reset after the low byte is taken: high byte must never be accepted
    TX_READY = 0;
    push_hdr();
    exp_q.push_back(8'h34);
    pulse(16'h1234);
    TX_READY = 1;
    drain(20);
    #1 TX_READY = 0; RST = 1;
    @(posedge CLK); #1 RST = 0;
    seq_tb = '0;
    @(negedge CLK);
    chk("mid_rst_valid", TX_VALID, 0);
    chk("mid_rst_busy", BUSY, 0);
    chk("mid_rst_full", FIFO_FULL, 0);
    chk("mid_rst_data", TX_DATA, 0);
    TX_READY = 1;
    repeat (4) @(negedge CLK);
    chk("mid_rst_idle", TX_VALID, 0);
    // sequence header restarts from zero after reset
    push_word(16'h1234);
    push_word(16'h5678);
    pulse(16'h1234);
    pulse(16'h5678);
    drain(30);
    @(negedge CLK);
    chk("final_busy", BUSY, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/alu_result_serializer.md
Name: alu_result_serializer

Overview:
- Downstream stage of the ALU logic/arithmetic units. Captures each registered ALU result when its OUT_VALID pulses and buffers it in a small FIFO.
- Serializes each buffered result into bytes, LSB first, over a valid/ready handshake toward the UART TX path.
- Decouples single-cycle ALU result pulses from a slower, back-pressured byte consumer.

Parameters:
- IN_WIDTH, 16, ALU result width; must be an integer multiple of BYTE_WIDTH.
- BYTE_WIDTH, 8, output byte width.
- DEPTH, 4, FIFO entries; power of two, at least 2.
- Derived: BYTES = IN_WIDTH/BYTE_WIDTH (2 at defaults).

Ports:
- CLK  in  1  single clock; all logic on the rising edge.
- RST  in  1  synchronous, active-high reset.
- ALU_OUT  in  IN_WIDTH  ALU result; sampled only when OUT_VALID=1.
- OUT_VALID  in  1  result strobe, one cycle per result.
- TX_DATA  out  BYTE_WIDTH  current byte.
- TX_VALID  out  1  TX_DATA valid.
- TX_READY  in  1  consumer accepts the byte when TX_VALID and TX_READY are both 1.
- FIFO_FULL  out  1  registered; count==DEPTH.
- DROP_PULSE  out  1  one-cycle pulse; a result was discarded.
- BUSY  out  1  state==SEND or count!=0.

Behaviour:
- Reset: on a rising edge with RST=1, FIFO pointers and count clear, the shift register clears, state goes to IDLE, and byte_cnt clears.
  - TX_DATA=0, TX_VALID=0, FIFO_FULL=0, DROP_PULSE=0, BUSY=0 from the following cycle.
  - Reset overrides all other inputs in that cycle.
- FIFO write: occurs when OUT_VALID=1 and (count<DEPTH, or a pop happens in the same cycle).
  - Simultaneous write and pop: count unchanged, pointers both advance, each wrapping modulo DEPTH.
- Drop: OUT_VALID=1 with count==DEPTH and no pop that cycle. The result is discarded, FIFO is unchanged, and DROP_PULSE=1 in the next cycle only.
- Pop: loads the head word into the shift register and sets byte_cnt=0.
- State IDLE: TX_VALID=0. If count!=0, pop and go to SEND.
- State SEND: TX_VALID=1, TX_DATA = shift register bits [BYTE_WIDTH-1:0].
  - While TX_READY=0: TX_DATA, TX_VALID and the shift register hold stable.
  - Accept with byte_cnt<BYTES-1: shift right by BYTE_WIDTH and increment byte_cnt.
  - Accept with byte_cnt==BYTES-1: if count!=0, pop and stay in SEND with no bubble cycle. Otherwise go to IDLE, and TX_VALID=0 next cycle.
- Latency: a result written at edge k (empty FIFO, IDLE) is popped at edge k+1. TX_VALID is high after edge k+1, i.e. in the second cycle after the OUT_VALID cycle. With TX_READY=1, one byte per cycle.
- Ordering: results leave in arrival order; bytes within a result go LSB first.
- Mid-transfer reset: the partial word and all FIFO contents are lost. No further bytes of that word are emitted.

Optional Feature:
- Macro: ALU_RES_SEQ_HDR_EN.
- Defined:
  - Each popped word is preceded by one header byte equal to an internal BYTE_WIDTH-bit sequence counter. The counter resets to 0 and increments after each header is accepted, wrapping from all-ones to 0.
  - The word occupies BYTES+1 transfers. The header follows the same handshake rules as data bytes.
  - Back-to-back words continue with no bubble: header, data bytes, next header.
- Undefined: no header, no counter logic; behaviour exactly as above.

Test Plan:
- Reset, ALU_OUT=0x1234 with a one-cycle OUT_VALID, TX_READY=1 -> TX_DATA 0x34 then 0x12 on consecutive cycles. TX_VALID is high exactly 2 cycles, starting the second cycle after the pulse. BUSY then falls to 0.
- Result 0xBEEF with TX_READY=0 for 5 cycles, then 1 -> TX_DATA holds 0xEF with TX_VALID=1 for all 5 stall cycles, then 0xEF and 0xBE are accepted.
- TX_READY=0, six consecutive pulses 0x0001..0x0006:
  - 0x0001 is in the shift register and 0x0002..0x0005 fill the FIFO, so FIFO_FULL=1.
  - 0x0006 is dropped and DROP_PULSE=1 for one cycle.
  - Releasing ready yields 01 00 02 00 03 00 04 00 05 00, with no 0x06.
- Pulses 0xAAAA then 0x5555 one cycle apart, TX_READY=1 -> AA AA 55 55 on four contiguous TX_VALID cycles, no bubble.
- Result 0x1234; after 0x34 is accepted, RST=1 for one cycle -> TX_VALID=0 the next cycle, 0x12 never appears, BUSY=0, FIFO empty.
- With ALU_RES_SEQ_HDR_EN: results 0x1234 and 0x5678, TX_READY=1 -> 00 34 12 01 78 56.
